// File: rtl/safe_lock_pkg.sv
// safe_lock_pkg: shared state encoding and default sizing for the safe lock controller
package safe_lock_pkg;
    localparam int N_DEF           = 4;
    localparam int MAX_FAILS_DEF   = 3;
    localparam int OPEN_CYC_DEF    = 8;
    localparam int LOCKOUT_CYC_DEF = 16;
    localparam int RES_TIMEOUT_DEF = 8;
    typedef enum logic [2:0] {IDLE, SHIFT, WAIT_RES, OPEN, LOCKOUT} state_e;
endpackage

// File: rtl/safe_lock_timer.sv
// safe_lock_timer: loadable down-counter; done_o is high on the last cycle of a loaded interval
module safe_lock_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start_i,
    input  logic [W-1:0] load_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // reload on start, otherwise count down and rest at zero
    always_comb cnt_d = start_i ? load_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    // counter register
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    assign done_o = (cnt_q == W'(1));
endmodule

// File: rtl/safe_lock_ctrl.sv
// safe_lock_ctrl: keypad-to-serial-checker lock controller with unlock window and failure lockout
module safe_lock_ctrl import safe_lock_pkg::*; #(
    parameter int N           = N_DEF,
    parameter int MAX_FAILS   = MAX_FAILS_DEF,
    parameter int OPEN_CYC    = OPEN_CYC_DEF,
    parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF,
    parameter int RES_TIMEOUT = RES_TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           code_val,
    input  logic [N-1:0]                   code_data,
    output logic                           code_ready,
    output logic                           ser_val,
    output logic                           ser_data,
    input  logic                           ser_ready,
    input  logic                           chk_val,
    input  logic                           chk_data,
    output logic                           unlock,
    output logic                           locked_out,
    output logic                           alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);
    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int BW   = $clog2(N + 1);
    localparam int TM1  = OPEN_CYC > LOCKOUT_CYC ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TMAX = TM1 > RES_TIMEOUT ? TM1 : RES_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    state_e          state_q, state_d;
    logic [N-1:0]    sh_q, sh_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [FW-1:0]   fail_q, fail_d, fail_nxt;
    logic            alarm_q, alarm_d;
    logic            t_start, t_done, res_ok, res_fail;
    logic [TW-1:0]   t_load;

    safe_lock_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (t_start),
        .load_i  (t_load),
        .done_o  (t_done)
    );

    assign fail_nxt = (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + 1'b1;

    // next state: a checker result in SHIFT/WAIT_RES ends the attempt at once, unsent bits are dropped
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bcnt_d   = bcnt_q;
        fail_d   = fail_q;
        alarm_d  = 1'b0;
        t_start  = 1'b0;
        t_load   = '0;
        res_ok   = 1'b0;
        res_fail = 1'b0;
        case (state_q)
            IDLE: if (code_val) begin
                sh_d    = code_data;
                bcnt_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: if (chk_val) begin
                res_ok   = chk_data;
                res_fail = !chk_data;
            end else if (ser_ready) begin
                sh_d   = sh_q << 1;
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == BW'(N - 1)) begin
                    state_d = WAIT_RES;
                    t_start = 1'b1;
                    t_load  = TW'(RES_TIMEOUT);
                end
            end
            WAIT_RES: if (chk_val) begin
                res_ok   = chk_data;
                res_fail = !chk_data;
            end else if (t_done) res_fail = 1'b1;
            OPEN: if (t_done) state_d = IDLE;
            LOCKOUT: if (t_done) begin
                fail_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (res_ok) begin
            fail_d  = '0;
            state_d = OPEN;
            t_start = 1'b1;
            t_load  = TW'(OPEN_CYC);
        end
        if (res_fail) begin
            fail_d  = fail_nxt;
            state_d = IDLE;
            if (fail_nxt == FW'(MAX_FAILS)) begin
                state_d = LOCKOUT;
                alarm_d = 1'b1;
                t_start = 1'b1;
                t_load  = TW'(LOCKOUT_CYC);
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcnt_q  <= '0;
            fail_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            fail_q  <= fail_d;
            alarm_q <= alarm_d;
        end

    assign code_ready = (state_q == IDLE);
    assign ser_val    = (state_q == SHIFT);
    assign ser_data   = (state_q == SHIFT) && sh_q[N-1];
    assign unlock     = (state_q == OPEN);
    assign locked_out = (state_q == LOCKOUT);
    assign alarm      = alarm_q;
    assign fail_cnt   = fail_q;
endmodule

// File: tb/tb_safe_lock_ctrl.sv
// tb_safe_lock_ctrl: directed scoreboard bench for safe_lock_ctrl
module tb_safe_lock_ctrl;
    localparam int N = 4;
    logic clk = 1'b0, rstn = 1'b0, code_val = 1'b0, ser_ready = 1'b0, chk_val = 1'b0, chk_data = 1'b0;
    logic [N-1:0] code_data = '0;
    logic code_ready, ser_val, ser_data, unlock, locked_out, alarm;
    logic [1:0] fail_cnt;
    int n_chk = 0, n_fail = 0;
    int exp_bits[$], exp_open[$], exp_lock[$];
    int urun = 0, lrun = 0, arun = 0;
    int n;

    always #5 clk = ~clk;

    safe_lock_ctrl #(.N(N), .MAX_FAILS(3), .OPEN_CYC(8), .LOCKOUT_CYC(16), .RES_TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .code_val(code_val), .code_data(code_data), .code_ready(code_ready),
        .ser_val(ser_val), .ser_data(ser_data), .ser_ready(ser_ready), .chk_val(chk_val),
        .chk_data(chk_data), .unlock(unlock), .locked_out(locked_out), .alarm(alarm), .fail_cnt(fail_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] c);
        code_val = 1'b1;
        code_data = c;
        tick();
        code_val = 1'b0;
        chk("code_accepted", ser_val, 1);
    endtask

    task automatic wait_idle(input int lim, output int cnt);
        cnt = 0;
        while (!code_ready && cnt < lim) begin
            tick();
            cnt++;
        end
        chk("idle_reached", code_ready, 1);
    endtask

    task automatic push_bits(input logic [N-1:0] c, input int k);
        for (int i = 0; i < k; i++) exp_bits.push_back(int'(c[N-1-i]));
    endtask

    // monitor: serial bits, unlock windows and lockout windows against the scoreboard queues
    always @(negedge clk) begin
        if (!rstn) begin
            urun = 0;
            lrun = 0;
            arun = 0;
        end else begin
            if (ser_val && ser_ready) begin
                chk("bit_expected", int'(exp_bits.size() > 0), 1);
                if (exp_bits.size() > 0) chk("ser_bit", ser_data, exp_bits.pop_front());
            end
            if (unlock) urun++;
            else if (urun > 0) begin
                chk("open_expected", int'(exp_open.size() > 0), 1);
                if (exp_open.size() > 0) chk("unlock_len", urun, exp_open.pop_front());
                urun = 0;
            end
            if (locked_out) begin
                lrun++;
                arun += int'(alarm);
            end else if (lrun > 0) begin
                chk("lockout_expected", int'(exp_lock.size() > 0), 1);
                if (exp_lock.size() > 0) chk("lockout_len", lrun, exp_lock.pop_front());
                chk("alarm_pulses", arun, 1);
                lrun = 0;
                arun = 0;
            end
            if (alarm) chk("alarm_in_lockout", locked_out, 1);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_code_ready", code_ready, 1);
        chk("rst_ser_val", ser_val, 0);
        chk("rst_ser_data", ser_data, 0);
        chk("rst_unlock", unlock, 0);
        chk("rst_locked_out", locked_out, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        rstn = 1'b1;
        tick();
        // correct code, result on the last bit
        push_bits(4'b1011, 4);
        exp_open.push_back(8);
        send(4'b1011);
        ser_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin chk_val = 1'b1; chk_data = 1'b1; end
            tick();
        end
        chk_val = 1'b0;
        ser_ready = 1'b0;
        chk("t1_unlock", unlock, 1);
        chk("t1_fail_cnt", fail_cnt, 0);
        wait_idle(20, n);
        chk("t1_open_cycles", n, 8);
        // early reject after the first bit
        push_bits(4'b0011, 1);
        send(4'b0011);
        ser_ready = 1'b1;
        tick();
        ser_ready = 1'b0;
        chk_val = 1'b1;
        chk_data = 1'b0;
        tick();
        chk_val = 1'b0;
        chk("t2_code_ready", code_ready, 1);
        chk("t2_fail_cnt", fail_cnt, 1);
        ser_ready = 1'b1;
        tick();
        chk("t2_ser_val", ser_val, 0);
        ser_ready = 1'b0;
        // no result: timeout in WAIT_RES
        push_bits(4'b1000, 4);
        send(4'b1000);
        ser_ready = 1'b1;
        repeat (4) tick();
        chk("t3_ser_val", ser_val, 0);
        chk("t3_code_ready", code_ready, 0);
        wait_idle(30, n);
        ser_ready = 1'b0;
        chk("t3_timeout_cycles", n, 8);
        chk("t3_fail_cnt", fail_cnt, 2);
        // third consecutive failure, result on the last bit: lockout
        push_bits(4'b0101, 4);
        exp_lock.push_back(16);
        send(4'b0101);
        ser_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin chk_val = 1'b1; chk_data = 1'b0; end
            tick();
        end
        chk("t4_locked_out", locked_out, 1);
        chk("t4_alarm_first", alarm, 1);
        chk("t4_fail_cnt", fail_cnt, 3);
        chk("t4_code_ready", code_ready, 0);
        code_val = 1'b1;
        code_data = 4'b1011;
        chk_data = 1'b1;
        tick();
        n = 1;
        chk("t4_alarm_second", alarm, 0);
        repeat (12) begin tick(); n++; end
        chk("t4_still_locked", locked_out, 1);
        code_val = 1'b0;
        chk_val = 1'b0;
        ser_ready = 1'b0;
        while (!code_ready && n < 40) begin tick(); n++; end
        chk("t4_lockout_cycles", n, 16);
        chk("t4_fail_cleared", fail_cnt, 0);
        tick();
        chk("t4_not_buffered", code_ready, 1);
        chk("t4_no_shift", ser_val, 0);
        // ser_ready stall mid-shift, then correct result on the last bit
        push_bits(4'b1101, 4);
        exp_open.push_back(8);
        send(4'b1101);
        ser_ready = 1'b1;
        tick();
        tick();
        ser_ready = 1'b0;
        repeat (5) begin
            chk("t5_stall_data", ser_data, 0);
            chk("t5_stall_val", ser_val, 1);
            tick();
        end
        ser_ready = 1'b1;
        tick();
        chk_val = 1'b1;
        chk_data = 1'b1;
        tick();
        chk_val = 1'b0;
        ser_ready = 1'b0;
        wait_idle(20, n);
        chk("t5_open_cycles", n, 8);
        // reset during OPEN
        push_bits(4'b1011, 4);
        send(4'b1011);
        ser_ready = 1'b1;
        repeat (3) tick();
        chk_val = 1'b1;
        chk_data = 1'b1;
        tick();
        chk_val = 1'b0;
        ser_ready = 1'b0;
        tick();
        tick();
        chk("t6_unlock_before", unlock, 1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_unlock", unlock, 0);
        chk("t6_rst_code_ready", code_ready, 1);
        chk("t6_rst_ser_val", ser_val, 0);
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_idle", code_ready, 1);
        chk("t6_unlock_after", unlock, 0);
        // reject with no bits sent, then reset during SHIFT
        send(4'b1110);
        chk_val = 1'b1;
        chk_data = 1'b0;
        tick();
        chk_val = 1'b0;
        chk("t7_fail_cnt", fail_cnt, 1);
        chk("t7_code_ready", code_ready, 1);
        push_bits(4'b1111, 2);
        send(4'b1111);
        ser_ready = 1'b1;
        tick();
        tick();
        ser_ready = 1'b0;
        chk("t7_mid_shift", ser_val, 1);
        rstn = 1'b0;
        #1;
        chk("t7_rst_ser_val", ser_val, 0);
        chk("t7_rst_ser_data", ser_data, 0);
        chk("t7_rst_fail_cnt", fail_cnt, 0);
        chk("t7_rst_code_ready", code_ready, 1);
        tick();
        rstn = 1'b1;
        tick();
        chk("t7_idle", code_ready, 1);
        chk("t7_ser_val_after", ser_val, 0);
        tick();
        tick();
        chk("bits_left", exp_bits.size(), 0);
        chk("opens_left", exp_open.size(), 0);
        chk("lockouts_left", exp_lock.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
